// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: 8-way round-robin arbiter with one-hot grant, owner release and hold timeout
module onehot_rr_arbiter #(
  parameter int N        = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [N-1:0] gnt_n, rot;
  logic [IDXW-1:0] idx_n, ptr, ptr_n, win;
  logic [7:0] cnt, cnt_n;
  logic valid_n, to_n, at_max, rel;
  // winner search: rotate so ptr lands on bit 0, lowest set bit wins
  always_comb begin
    rot = N'({req, req} >> ptr);
    win = ptr;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) win = ptr + IDXW'(i);
  end
  // next-state and next-output logic; release outranks everything while granted
  always_comb begin
    at_max  = cnt == 8'(MAX_HOLD);
    rel     = done | ~req[gnt_idx] | at_max;
    state_n = state;
    gnt_n   = gnt;
    idx_n   = gnt_idx;
    valid_n = gnt_valid;
    to_n    = 1'b0;
    ptr_n   = ptr;
    cnt_n   = cnt;
    if (state == IDLE) begin
      if (|req) begin
        state_n = GRANT;
        gnt_n   = N'(1) << win;
        idx_n   = win;
        valid_n = 1'b1;
        ptr_n   = win + IDXW'(1);
        cnt_n   = 8'd1;
      end
    end else if (rel) begin
      state_n = IDLE;
      gnt_n   = '0;
      valid_n = 1'b0;
      to_n    = at_max & ~done & req[gnt_idx];
      cnt_n   = 8'd0;
    end else cnt_n = cnt + 8'd1;
  end
  // state and registered outputs; async reset clears everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= '0;
      cnt       <= 8'd0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      gnt_idx   <= idx_n;
      gnt_valid <= valid_n;
      timeout   <= to_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
    end
  end
endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb_onehot_rr_arbiter: scoreboard bench for the round-robin arbiter
module tb_onehot_rr_arbiter;
  logic clk = 0, rst_n = 0, done = 0;
  logic [7:0] req = '0, gnt;
  logic [2:0] gnt_idx;
  logic gnt_valid, timeout;
  int checks = 0, failures = 0;
  typedef struct {int idx; int len; int to; int gap;} exp_t;
  exp_t q[$];
  exp_t cur;
  int len, idle;
  logic pv;

  onehot_rr_arbiter dut (.clk(clk), .rst_n(rst_n), .req(req), .done(done), .gnt(gnt),
    .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout));

  always #5 clk = ~clk;

  function automatic logic [7:0] oh(int i);
    return 8'd1 << i;
  endfunction

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push(int idx, int ln, int to, int gap);
    exp_t e;
    e.idx = idx; e.len = ln; e.to = to; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_grant();
    logic p;
    p = gnt_valid;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (gnt_valid && !p) return;
      p = gnt_valid;
    end
    checks++;
    failures++;
    $display("FAIL wait_grant got=no_grant want=grant");
  endtask

  task automatic pulse_done(int d);
    repeat (d) @(negedge clk);
    done = 1;
    @(negedge clk);
    done = 0;
  endtask

  // monitor: pops an expectation at each grant start, checks hold length and timeout at release
  initial begin
    pv = 0; len = 0; idle = 0;
    cur.idx = 0; cur.len = 0; cur.to = 0; cur.gap = -1;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pv = 0; len = 0; idle = 0;
        continue;
      end
      chk("invariant_gnt", gnt, gnt_valid ? oh(gnt_idx) : 0);
      if (!(pv && !gnt_valid)) chk("timeout_idle", timeout, 0);
      if (gnt_valid && !pv) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_grant got=%0d want=none", gnt_idx);
        end else begin
          cur = q.pop_front();
          chk("grant_idx", gnt_idx, cur.idx);
          chk("grant_onehot", gnt, oh(cur.idx));
          if (cur.gap >= 0) chk("grant_gap", idle, cur.gap);
        end
        len = 1;
      end else if (gnt_valid) len++;
      else if (pv) begin
        if (cur.len > 0) begin
          chk("hold_len", len, cur.len);
          chk("timeout_flag", timeout, cur.to);
        end
        idle = 1;
      end else idle++;
      pv = gnt_valid;
    end
  end

  initial begin
    #1;
    chk("reset_gnt", gnt, 0);
    chk("reset_valid", gnt_valid, 0);
    chk("reset_idx", gnt_idx, 0);
    chk("reset_timeout", timeout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_outputs", {gnt, gnt_idx, gnt_valid, timeout}, 0);
    end
    // two requesters, done two cycles into each grant
    do_reset();
    push(2, 2, 0, -1); push(5, 2, 0, 1); push(2, 2, 0, 1);
    req = 8'h24;
    for (int i = 0; i < 3; i++) begin wait_grant(); pulse_done(1); end
    req = 8'h00;
    // all requesting: strict rotation with single-cycle holds
    do_reset();
    push(0, 1, 0, -1);
    for (int i = 1; i < 8; i++) push(i, 1, 0, 1);
    push(0, 1, 0, 1);
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin wait_grant(); pulse_done(0); end
    req = 8'h00;
    // lone requester 7 never releases: forced timeout, then regrant after wrap
    do_reset();
    push(7, 16, 1, -1); push(7, 1, 0, 1);
    req = 8'h80;
    wait_grant();
    wait_grant();
    req = 8'h00;
    // done, dropped request and max hold all at once: no timeout
    do_reset();
    push(3, 16, 0, -1); push(3, 1, 0, 1);
    req = 8'h08;
    wait_grant();
    repeat (15) @(negedge clk);
    req = 8'h00; done = 1;
    @(negedge clk);
    req = 8'h08; done = 0;
    wait_grant();
    req = 8'h00;
    // reset mid-grant drops outputs asynchronously, arbitration restarts at 0
    do_reset();
    push(4, 0, 0, -1);
    req = 8'h10;
    wait_grant();
    @(negedge clk);
    push(0, 1, 0, -1); push(4, 1, 0, 1);
    rst_n = 0;
    req = 8'h11;
    #1;
    chk("async_gnt", gnt, 0);
    chk("async_valid", gnt_valid, 0);
    chk("async_idx", gnt_idx, 0);
    @(negedge clk);
    rst_n = 1;
    wait_grant(); pulse_done(0);
    wait_grant(); pulse_done(0);
    req = 8'h00;
    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/onehot_rr_arbiter.md
Name: onehot_rr_arbiter

Overview:
- 8-requester round-robin arbiter for a single shared resource.
- Grant is issued as an encoded index plus its 3-to-8 one-hot decode, the same mapping as the team's sel-to-one-hot decoder: idx 0 -> 8'b00000001 ... idx 7 -> 8'b10000000.
- Each grant is held until the owner releases it, drops its request, or hits a hold timeout.
- Sits between requesting agents and the one-hot select lines of the shared datapath.

Parameters:
- N, 8, number of requesters; fixed at 8 for this revision.
- IDXW, 3, width of the encoded grant index (log2 N).
- MAX_HOLD, 16, maximum cycles one grant is held before forced release; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i asserted by requester i.
- done  input  1  single-cycle release strobe from the current owner.
- gnt  output  8  registered one-hot grant; all-zero when no grant.
- gnt_idx  output  3  registered encoded index of the current or last owner.
- gnt_valid  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0, priority pointer ptr=3'd0, hold counter=0. Outputs change immediately on reset assertion, not at the next edge.
- Invariant: gnt_valid=1 implies gnt == onehot(gnt_idx). gnt_valid=0 implies gnt==0.
- States:
  - IDLE: no owner.
  - GRANT: owner = gnt_idx.
- IDLE, req==0: stay; outputs unchanged (gnt=0, valid=0).
- IDLE, req!=0:
  - Winner = first set bit scanning ptr, ptr+1, ... mod 8.
  - On this edge: gnt_idx<=winner, gnt<=onehot(winner), gnt_valid<=1, ptr<=winner+1 mod 8 (7 wraps to 0), counter<=1, go to GRANT.
  - Latency: request sampled at edge k; grant visible after edge k. No combinational path from req to gnt.
- GRANT release conditions, evaluated each edge:
  - (a) done=1.
  - (b) req[gnt_idx]=0.
  - (c) counter==MAX_HOLD.
- On release: gnt<=0, gnt_valid<=0, go to IDLE; gnt_idx keeps last owner.
  - timeout<=1 only when (c) is true and (a) and (b) are both false. Otherwise timeout<=0.
  - Release has priority over any other event in the same cycle.
- GRANT, no release condition: counter<=counter+1; outputs hold.
- Minimum one IDLE cycle between consecutive grants (bus turnaround). Re-arbitration happens in that IDLE cycle.
- Requests from non-owners during GRANT are ignored; they are not latched. A requester must hold req to be served.
- done asserted in IDLE is ignored.
- Fairness: with all 8 requesting continuously, grants rotate 0,1,2,...,7,0. Each requester is served within 8 grant slots.
- Reset mid-grant: gnt/valid drop asynchronously; after release, arbitration restarts from ptr=0.
- Counter width is 8 bits and never wraps, because release at MAX_HOLD is forced.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> gnt=0, gnt_valid=0, gnt_idx=0, timeout=0 throughout.
- From reset, req=8'h24 held, done pulsed 2 cycles after each grant -> first gnt=8'h04 (idx 2), then IDLE cycle, then gnt=8'h20 (idx 5), then gnt=8'h04 again.
- req=8'hFF held, done pulsed 1 cycle after each grant -> gnt_idx sequence 0,1,...,7,0. Each gnt equals the matching one-hot 8'h01..8'h80. Every grant separated by exactly one gnt=0 cycle.
- req=8'h80 held, never done, MAX_HOLD=16 -> gnt=8'h80 for exactly 16 cycles. timeout=1 for one cycle as gnt drops. Regrant of idx 7 follows one IDLE cycle later (ptr wrapped to 0; only bit 7 set).
- Owner idx 3 drops req[3] on the same cycle done=1 and counter==MAX_HOLD -> released, timeout stays 0, next state IDLE.
- Assert rst_n=0 while gnt=8'h10 -> gnt=0 and gnt_valid=0 before the next clock edge. After release with req=8'h11, first grant is idx 0 (8'h01).
